router_fifo: RTL and testbench

//   Per-destination output FIFO of the 1x3 router; sits directly downstream of the

---
 rtl/router_fifo.sv | 85 ++++++++
 tb/tb_router_fifo.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router. Each entry carries a header flag
// so the read side can count down a packet and pulse pkt_rd_done after its parity byte.
module router_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty,
  output logic              pkt_rd_done
);

  logic [DATA_W:0] mem [DEPTH];
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic [5:0]      pkt_cnt;
  logic            wr_acc;
  logic            rd_acc;
  logic            clear;
  logic [DATA_W:0] rd_entry;

  // One extra pointer bit separates the full case from the empty case.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign wr_acc   = write_enb && !full;
  assign rd_acc   = read_enb && !empty;
  assign clear    = reset || soft_reset;
  assign rd_entry = mem[rd_ptr[ADDR_W-1:0]];

  always_ff @(posedge clock) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_acc) begin
      mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // A header reloads the count with payload length plus parity; stray bytes at zero are ignored.
  always_ff @(posedge clock) begin
    if (clear) begin
      data_out    <= '0;
      pkt_cnt     <= '0;
      pkt_rd_done <= 1'b0;
    end else begin
      pkt_rd_done <= 1'b0;
      if (rd_acc) begin
        data_out <= rd_entry[DATA_W-1:0];
        if (rd_entry[DATA_W]) begin
          pkt_cnt <= rd_entry[7:2] + 6'd1;
        end else if (pkt_cnt != 6'd0) begin
          pkt_cnt <= pkt_cnt - 6'd1;
          if (pkt_cnt == 6'd1) begin
            pkt_rd_done <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Self-checking bench for router_fifo: a queue model of the stored entries is
// updated on every driven cycle and compared against all outputs after the edge.
module tb_router_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic       soft_reset;
  logic       write_enb;
  logic       read_enb;
  logic       lfd_state;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_rd_done;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] model_q[$];
  logic [7:0] exp_dout = 8'h00;
  logic [5:0] exp_cnt  = 6'd0;
  logic       exp_done = 1'b0;

  router_fifo dut (
    .clock       (clock),
    .reset       (reset),
    .soft_reset  (soft_reset),
    .write_enb   (write_enb),
    .read_enb    (read_enb),
    .lfd_state   (lfd_state),
    .data_in     (data_in),
    .data_out    (data_out),
    .full        (full),
    .empty       (empty),
    .pkt_rd_done (pkt_rd_done)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one cycle, advances the model using the pre-edge occupancy, then checks every output.
  task automatic applyStimulus(input logic rst, input logic srst, input logic wr, input logic rd,
                               input logic lfd, input logic [7:0] din);
    logic       acc_wr;
    logic       acc_rd;
    logic [8:0] e;
    reset      = rst;
    soft_reset = srst;
    write_enb  = wr;
    read_enb   = rd;
    lfd_state  = lfd;
    data_in    = din;
    acc_wr = wr && (model_q.size() < 16);
    acc_rd = rd && (model_q.size() != 0);
    @(posedge clock);
    #1;
    exp_done = 1'b0;
    if (rst || srst) begin
      model_q.delete();
      exp_dout = 8'h00;
      exp_cnt  = 6'd0;
    end else begin
      if (acc_rd) begin
        e = model_q.pop_front();
        exp_dout = e[7:0];
        if (e[8]) begin
          exp_cnt = e[7:2] + 6'd1;
        end else if (exp_cnt != 6'd0) begin
          if (exp_cnt == 6'd1) exp_done = 1'b1;
          exp_cnt = exp_cnt - 6'd1;
        end
      end
      if (acc_wr) model_q.push_back({lfd, din});
    end
    checkOutput("data_out", 32'(data_out), 32'(exp_dout));
    checkOutput("full", 32'(full), 32'(model_q.size() == 16));
    checkOutput("empty", 32'(empty), 32'(model_q.size() == 0));
    checkOutput("pkt_rd_done", 32'(pkt_rd_done), 32'(exp_done));
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic writeByte(input logic lfd, input logic [7:0] din);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, lfd, din);
  endtask

  task automatic readByte();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
  endtask

  int pulses;

  initial begin
    logic [7:0] pkt[5];
    pkt = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h1C};

    // Reset for two clocks.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    checkOutput("reset_empty", 32'(empty), 32'd1);
    checkOutput("reset_dout", 32'(data_out), 32'h00);
    idle();

    // One complete packet: pulse exactly once after parity.
    for (int i = 0; i < 5; i++) writeByte(i == 0, pkt[i]);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      readByte();
      checkOutput("pkt_byte", 32'(data_out), 32'(pkt[i]));
      if (pkt_rd_done) pulses++;
    end
    idle();
    if (pkt_rd_done) pulses++;
    idle();
    checkOutput("pkt_pulse_count", 32'(pulses), 32'd1);
    checkOutput("pkt_drained", 32'(empty), 32'd1);

    // Fill to full, drop a 17th write, drain in order.
    for (int i = 0; i < 16; i++) writeByte(1'b0, 8'(i));
    checkOutput("full_after16", 32'(full), 32'd1);
    writeByte(1'b0, 8'hFF);
    for (int i = 0; i < 16; i++) begin
      readByte();
      checkOutput("fill_order", 32'(data_out), 32'(i));
    end
    checkOutput("empty_after_drain", 32'(empty), 32'd1);

    // Simultaneous read/write at full and at empty.
    for (int i = 0; i < 16; i++) writeByte(1'b0, 8'(8'h40 + i));
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    checkOutput("full_rdwr_full", 32'(full), 32'd0);
    checkOutput("full_rdwr_dout", 32'(data_out), 32'h40);
    for (int i = 0; i < 15; i++) readByte();
    checkOutput("empty_before_rdwr", 32'(empty), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
    checkOutput("empty_rdwr_empty", 32'(empty), 32'd0);
    checkOutput("empty_rdwr_dout", 32'(data_out), 32'h4F);
    readByte();
    checkOutput("empty_rdwr_byte", 32'(data_out), 32'hAA);

    // Pointer wrap: 12 in, 10 out, 12 in, 14 out.
    for (int i = 0; i < 12; i++) writeByte(1'b0, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) readByte();
    for (int i = 0; i < 12; i++) writeByte(1'b0, 8'(8'hC0 + i));
    for (int i = 0; i < 14; i++) begin
      readByte();
      checkOutput("wrap_order", 32'(data_out), (i < 2) ? 32'(8'h8A + i) : 32'(8'hC0 + i - 2));
    end
    checkOutput("wrap_empty", 32'(empty), 32'd1);

    // Soft reset mid-packet discards the write and the packet count.
    writeByte(1'b1, 8'h15);
    for (int i = 1; i <= 6; i++) writeByte(1'b0, 8'(i));
    for (int i = 0; i < 3; i++) readByte();
    checkOutput("mid_pkt_cnt", 32'(dut.pkt_cnt), 32'd4);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
    checkOutput("srst_empty", 32'(empty), 32'd1);
    checkOutput("srst_dout", 32'(data_out), 32'h00);
    checkOutput("srst_pkt_cnt", 32'(dut.pkt_cnt), 32'd0);
    for (int i = 0; i < 4; i++) idle();
    // A stray byte after flush must not pulse.
    writeByte(1'b0, 8'h5A);
    readByte();
    idle();
    checkOutput("stray_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
